// File: rtl/bridge_pkg.sv
// Shared definitions for the UART bus bridge: frame layout, error response,
// and the master-side FSM state encoding.
package bridge_pkg;

    // Frame field offsets. The address starts at bit 0; three spare bits sit
    // between the address and the write data, followed by the mode bit.
    localparam int ADDR_LSB = 0;

    function automatic int wdata_lsb(input int addr_w);
        return addr_w + 3;
    endfunction

    function automatic int mode_bit(input int addr_w, input int data_w);
        return addr_w + 3 + data_w;
    endfunction

    // Response word returned when a read is aborted by timeout.
    localparam logic [15:0] RESP_ERR = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RSEND = 2'd2,
        RWAIT = 2'd3
    } state_e;

endpackage

// File: rtl/bridge_frame_buf.sv
// One-entry buffer for decoded request frames. A push lands if the entry is
// empty or is being popped in the same cycle; otherwise the frame is dropped
// and the sticky overflow flag is raised.
module bridge_frame_buf #(
    parameter int FRAME_W = 21
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               push,
    input  logic [FRAME_W-1:0] push_data,
    input  logic               pop,
    output logic               full,
    output logic [FRAME_W-1:0] pop_data,
    output logic               ovf
);

    logic               full_q, full_d;
    logic [FRAME_W-1:0] data_q, data_d;
    logic               ovf_q, ovf_d;

    // Next-state for occupancy, stored frame and overflow flag.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        ovf_d  = ovf_q;
        if (pop) begin
            full_d = 1'b0;
        end
        if (push) begin
            if (!full_q || pop) begin
                full_d = 1'b1;
                data_d = push_data;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // Buffer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            full_q <= 1'b0;
            data_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            ovf_q  <= ovf_d;
        end
    end

    assign full     = full_q;
    assign pop_data = data_q;
    assign ovf      = ovf_q;

endmodule

// File: rtl/bus_bridge_uart_master.sv
// Remote end of the UART bus bridge: decodes request frames, issues them one
// at a time on the master-request interface, and returns read responses to
// the UART transmitter.
module bus_bridge_uart_master
    import bridge_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [31:0]           rx_frame,
    input  logic                  rx_ready,
    output logic [15:0]           tx_data,
    output logic                  tx_en,
    input  logic                  tx_busy,
    output logic                  m_req,
    output logic                  m_wen,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_ack,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  busy,
    output logic                  ovf,
    output logic                  tmo
);

    localparam int WDATA_LSB = wdata_lsb(ADDR_WIDTH);
    localparam int MODE_BIT  = mode_bit(ADDR_WIDTH, DATA_WIDTH);
    localparam int FRAME_W   = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam int CNT_W     = $clog2(TIMEOUT_CYCLES);

    // Only the decoded fields are buffered; spare and upper frame bits are
    // gathered here so they are visibly discarded.
    logic unused_frame_bits;
    if (MODE_BIT < 31) begin : g_upper
        assign unused_frame_bits = ^{rx_frame[31:MODE_BIT+1], rx_frame[WDATA_LSB-1:ADDR_WIDTH]};
    end else begin : g_no_upper
        assign unused_frame_bits = ^rx_frame[WDATA_LSB-1:ADDR_WIDTH];
    end

    logic [FRAME_W-1:0] push_data;
    logic [FRAME_W-1:0] pop_data;
    logic               buf_full;
    logic               pop;

    assign push_data = {rx_frame[MODE_BIT],
                        rx_frame[WDATA_LSB +: DATA_WIDTH],
                        rx_frame[ADDR_LSB +: ADDR_WIDTH]};

    bridge_frame_buf #(
        .FRAME_W (FRAME_W)
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .push      (rx_ready),
        .push_data (push_data),
        .pop       (pop),
        .full      (buf_full),
        .pop_data  (pop_data),
        .ovf       (ovf)
    );

    state_e                state_q, state_d;
    logic                  m_req_q, m_req_d;
    logic                  m_wen_q, m_wen_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic [15:0]           tx_data_q, tx_data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tmo_q, tmo_d;

    // Next-state and register updates for the transaction FSM. The counter
    // measures the wait for m_ack in REQ and the busy-handshake wait in RWAIT.
    always_comb begin
        state_d   = state_q;
        m_req_d   = m_req_q;
        m_wen_d   = m_wen_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        tx_data_d = tx_data_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (buf_full) begin
                    pop       = 1'b1;
                    m_addr_d  = pop_data[ADDR_WIDTH-1:0];
                    m_wdata_d = pop_data[ADDR_WIDTH +: DATA_WIDTH];
                    m_wen_d   = pop_data[FRAME_W-1];
                    m_req_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (m_ack) begin
                    m_req_d = 1'b0;
                    cnt_d   = '0;
                    if (m_wen_q) begin
                        state_d = IDLE;
                    end else begin
                        tx_data_d = 16'(m_rdata);
                        state_d   = RSEND;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    m_req_d = 1'b0;
                    tmo_d   = 1'b1;
                    cnt_d   = '0;
                    if (m_wen_q) begin
                        state_d = IDLE;
                    end else begin
                        tx_data_d = RESP_ERR;
                        state_d   = RSEND;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RSEND: begin
                if (!tx_busy) begin
                    cnt_d   = '0;
                    state_d = RWAIT;
                end
            end
            RWAIT: begin
                if (tx_busy || cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            m_wen_q   <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            tx_data_q <= '0;
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_wen_q   <= m_wen_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    // The launch strobe fires in the first RSEND cycle the transmitter is
    // free, so a read ack reaches tx_en one cycle later when tx_busy is low.
    assign tx_en   = (state_q == RSEND) && !tx_busy;
    assign tx_data = tx_data_q;
    assign m_req   = m_req_q;
    assign m_wen   = m_wen_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign tmo     = tmo_q;
    assign busy    = (state_q != IDLE) || buf_full;

endmodule

// File: tb/tb_bus_bridge_uart_master.sv
// Self-checking bench for bus_bridge_uart_master: a transaction-level model
// predicts every output each cycle, plus directed literal checks.
module tb_bus_bridge_uart_master;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int T  = 16;

    localparam int P_IDLE = 0, P_REQ = 1, P_SEND = 2, P_WAIT = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic [31:0]   rx_frame;
    logic          rx_ready;
    logic [15:0]   tx_data;
    logic          tx_en;
    logic          tx_busy;
    logic          m_req;
    logic          m_wen;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_ack;
    logic [DW-1:0] m_rdata;
    logic          busy;
    logic          ovf;
    logic          tmo;

    bus_bridge_uart_master #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_frame (rx_frame),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .tx_busy  (tx_busy),
        .m_req    (m_req),
        .m_wen    (m_wen),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ack    (m_ack),
        .m_rdata  (m_rdata),
        .busy     (busy),
        .ovf      (ovf),
        .tmo      (tmo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame field decode straight from the layout: {mode, wdata, addr}.
    function automatic logic [AW+DW:0] decode(input logic [31:0] f);
        int unsigned a, w, m;
        a = f % 4096;
        w = (f / 32768) % 256;
        m = (f / 8388608) % 2;
        return {m[0], w[DW-1:0], a[AW-1:0]};
    endfunction

    function automatic logic [31:0] mk(input int mode, input int wd, input int addr);
        return (mode << 23) | (wd << 15) | addr;
    endfunction

    // Reference model state: pending frames, current transaction, response.
    logic [31:0]   bq[$];
    int            ph, age, wage;
    logic          e_req, e_wen, e_ovf, e_tmo;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [15:0]   e_resp;

    // Bench-side observations and stimulus controls.
    int          cyc = 0;
    int          s_req = 0;
    int          ack_dly = 0;
    bit          rand_mode = 0;
    int          tx_seen = 0, req_hi = 0, ack_cyc = -1, tx_cyc = -1, rise_cyc = -1;
    logic [15:0] last_tx = '0;
    logic        prev_req = 0;
    logic [AW-1:0] obs_addr = '0;
    logic [DW-1:0] obs_wdata = '0;
    logic          obs_wen = 0;
    logic [AW-1:0] rise_addr[$];

    task automatic model_reset();
        bq.delete();
        ph = P_IDLE; age = 0; wage = 0;
        e_req = 0; e_wen = 0; e_ovf = 0; e_tmo = 0;
        e_addr = '0; e_wdata = '0; e_resp = '0;
    endtask

    task automatic model_step();
        bit had, popped;
        logic [AW+DW:0] d;
        if (!rstn) begin
            model_reset();
            return;
        end
        had = (bq.size() != 0);
        popped = 0;
        case (ph)
            P_IDLE: if (had) begin
                d = decode(bq.pop_front());
                {e_wen, e_wdata, e_addr} = d;
                e_req = 1; ph = P_REQ; age = 0; popped = 1;
            end
            P_REQ: begin
                if (m_ack || age == T - 1) begin
                    e_req = 0;
                    if (!m_ack) e_tmo = 1;
                    if (e_wen) ph = P_IDLE;
                    else begin
                        e_resp = m_ack ? {8'h00, m_rdata} : 16'hFFFF;
                        ph = P_SEND;
                    end
                end else age++;
            end
            P_SEND: if (!tx_busy) begin ph = P_WAIT; wage = 0; end
            default: if (tx_busy || wage == 1) ph = P_IDLE; else wage++;
        endcase
        if (rx_ready) begin
            if (!had || popped) bq.push_back(rx_frame);
            else e_ovf = 1;
        end
    endtask

    task automatic compare();
        logic exp_tx_en;
        exp_tx_en = (ph == P_SEND) && !tx_busy;
        chk("m_req", m_req, e_req);
        chk("m_wen", m_wen, e_wen);
        chk("m_addr", m_addr, e_addr);
        chk("m_wdata", m_wdata, e_wdata);
        chk("tx_en", tx_en, exp_tx_en);
        chk("tx_data", tx_data, e_resp);
        chk("busy", busy, (ph != P_IDLE) || (bq.size() != 0));
        chk("ovf", ovf, e_ovf);
        chk("tmo", tmo, e_tmo);
        if (m_req === 1'b1) begin
            req_hi++;
            obs_addr = m_addr; obs_wdata = m_wdata; obs_wen = m_wen;
            if (!prev_req) begin
                rise_cyc = cyc;
                rise_addr.push_back(m_addr);
            end
        end
        prev_req = (m_req === 1'b1);
        if (tx_en === 1'b1) begin
            tx_seen++; tx_cyc = cyc; last_tx = tx_data;
        end
    endtask

    // Completer: acknowledges ack_dly cycles after m_req rises (-1 = never).
    task automatic drive_resp();
        m_ack = 0;
        if (rand_mode) m_rdata = DW'($urandom);
        if (e_req) begin
            if (s_req == ack_dly) begin
                m_ack = 1; ack_cyc = cyc;
            end
            s_req++;
        end else begin
            s_req = 0;
            if (rand_mode) begin
                ack_dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
                if ($urandom_range(0, 9) == 0) m_ack = 1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        model_step();
        compare();
        drive_resp();
    endtask

    task automatic send(input logic [31:0] f);
        rx_frame = f; rx_ready = 1;
        cycle();
        rx_ready = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int rx_cyc, tx0, req0;

    initial begin
        rstn = 0; rx_frame = '0; rx_ready = 0; tx_busy = 0; m_ack = 0; m_rdata = '0;
        model_reset();

        // Model decode pinned to hand-computed fields.
        chk("decode_write", decode(32'h00A0_0123), {1'b1, 8'h40, 12'h123});
        chk("decode_read", decode(32'h0000_00FF), {1'b0, 8'h00, 12'h0FF});

        run(3);
        chk("reset_outputs", {m_req, tx_en, busy, ovf, tmo, tx_data}, '0);
        rstn = 1;
        run(2);

        // Directed write with ack three cycles after m_req.
        ack_dly = 3; tx0 = tx_seen;
        rx_cyc = cyc;
        send(32'h00A0_0123);
        run(12);
        chk("wr_latency", rise_cyc - rx_cyc, 2);
        chk("wr_fields", {obs_wen, obs_wdata, obs_addr}, {1'b1, 8'h40, 12'h123});
        chk("wr_no_tx", tx_seen - tx0, 0);
        chk("wr_idle", busy, 0);

        // Directed read returning 0x5A.
        ack_dly = 1; m_rdata = 8'h5A; tx0 = tx_seen;
        send(32'h0000_00FF);
        run(12);
        chk("rd_tx_count", tx_seen - tx0, 1);
        chk("rd_tx_data", last_tx, 16'h005A);
        chk("rd_latency", tx_cyc - ack_cyc, 1);

        // Back-to-back write then read, one idle cycle apart.
        ack_dly = 0; m_rdata = 8'hC3; rise_addr.delete(); tx0 = tx_seen;
        send(mk(1, 8'h33, 12'h010));
        cycle();
        send(mk(0, 0, 12'h020));
        run(16);
        chk("b2b_count", rise_addr.size(), 2);
        if (rise_addr.size() == 2) begin
            chk("b2b_order0", rise_addr[0], 12'h010);
            chk("b2b_order1", rise_addr[1], 12'h020);
        end
        chk("b2b_tx", last_tx, 16'h00C3);
        chk("b2b_ovf", ovf, 0);

        // Overflow: three frames while the first ack is withheld.
        ack_dly = 8; rise_addr.delete();
        send(mk(1, 8'h11, 12'h100));
        send(mk(1, 8'h22, 12'h200));
        send(mk(1, 8'h44, 12'h300));
        run(30);
        chk("ovf_set", ovf, 1);
        chk("ovf_count", rise_addr.size(), 2);
        if (rise_addr.size() == 2) begin
            chk("ovf_order0", rise_addr[0], 12'h100);
            chk("ovf_order1", rise_addr[1], 12'h200);
        end

        // Timeout on a read with no ack.
        ack_dly = -1; req0 = req_hi; tx0 = tx_seen;
        send(mk(0, 0, 12'h0AB));
        run(30);
        chk("tmo_req_len", req_hi - req0, T);
        chk("tmo_flag", tmo, 1);
        chk("tmo_tx_count", tx_seen - tx0, 1);
        chk("tmo_tx_data", last_tx, 16'hFFFF);

        // Randomized traffic.
        rand_mode = 1;
        for (int i = 0; i < 500; i++) begin
            tx_busy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) send($urandom);
            else cycle();
        end
        rand_mode = 0; tx_busy = 0; ack_dly = 0;
        run(60);
        chk("drain_idle", busy, 0);

        // Reset while a read response waits in RSEND behind a busy transmitter.
        tx_busy = 1; ack_dly = 0;
        send(mk(0, 0, 12'h055));
        begin
            int n;
            n = 0;
            while (ph != P_SEND && n < 20) begin cycle(); n++; end
            chk("reach_rsend", ph, P_SEND);
        end
        rstn = 0;
        cycle();
        chk("rst_mid_outputs", {m_req, tx_en, busy, ovf, tmo, tx_data, m_addr}, '0);
        rstn = 1; tx_busy = 0; tx0 = tx_seen;
        run(10);
        chk("rst_no_tx", tx_seen - tx0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
